// File: rtl/ysyx_23060072_wb_arbiter_if.sv
// Writeback arbitration bus: four producer request lanes in, one registered
// register-file write port (plus source/error side-band) out.
interface ysyx_23060072_wb_arbiter_if;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*ADDR_W-1:0] req_addr_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic                    wb_flag_o;
  logic [ADDR_W-1:0]       wb_addr_o;
  logic [DATA_W-1:0]       wb_data_o;
  logic [SRC_W-1:0]        wb_src_o;
  logic                    wb_err_o;

  // Producer side: drives requests, observes grants and the write port
  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, wb_flag_o, wb_addr_o, wb_data_o, wb_src_o, wb_err_o
  );

  // Arbiter side
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, wb_flag_o, wb_addr_o, wb_data_o, wb_src_o, wb_err_o
  );
endinterface

// File: rtl/ysyx_23060072_wb_arbiter.sv
// Register-file write-port arbiter: fixed priority (CSR > LSU > MDU > ALU)
// with starvation promotion, registered writeback, x0 / RV32E address filtering.
module ysyx_23060072_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input logic                        clk,
  input logic                        rst_n,
  ysyx_23060072_wb_arbiter_if.slave  bus
);
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;

  logic [CNT_W-1:0]  cnt [N_REQ];
  logic [N_REQ-1:0]  urgent;
  logic [N_REQ-1:0]  grant;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              wb_flag_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [SRC_W-1:0]  wb_src_q;
  logic              wb_err_q;

  // A requester is urgent once its stall counter has saturated
  always_comb begin
    urgent = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      urgent[i] = bus.req_valid_i[i] & (cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Lowest-index urgent requester wins; otherwise lowest-index valid one.
  // Scanning downward lets the lowest index overwrite earlier picks.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req_valid_i[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gnt_idx  = SRC_W'(i);
        gnt_any  = 1'b1;
      end
    end
    if (|urgent) begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        if (urgent[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          gnt_idx  = SRC_W'(i);
        end
      end
    end
  end

  assign sel_addr = bus.req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data_i[gnt_idx*DATA_W +: DATA_W];

  assign bus.req_ready_o = grant;

  // Stall counters: clear when idle or served, count up to the limit otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_REQ); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!bus.req_valid_i[i] || grant[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Writeback register: x0 is swallowed silently, x16..x31 raise an error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_flag_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
      wb_err_q  <= 1'b0;
    end else if (gnt_any) begin
      wb_flag_q <= (sel_addr != '0) && !sel_addr[ADDR_W-1];
      wb_addr_q <= sel_addr;
      wb_data_q <= sel_data;
      wb_src_q  <= gnt_idx;
      wb_err_q  <= sel_addr[ADDR_W-1];
    end else begin
      wb_flag_q <= 1'b0;
      wb_err_q  <= 1'b0;
    end
  end

  assign bus.wb_flag_o = wb_flag_q;
  assign bus.wb_addr_o = wb_addr_q;
  assign bus.wb_data_o = wb_data_q;
  assign bus.wb_src_o  = wb_src_q;
  assign bus.wb_err_o  = wb_err_q;
endmodule

// File: tb/tb_ysyx_23060072_wb_arbiter.sv
// Bench for the writeback arbiter: directed vector table, hand-written
// starvation / reset sequences and random traffic against a queue-free model.
module tb_ysyx_23060072_wb_arbiter;
  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ysyx_23060072_wb_arbiter_if bus ();

  ysyx_23060072_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Reference model: cycles each requester has been kept waiting, plus the
  // write-port value the arbiter should be presenting.
  int          waited [4];
  logic        m_flag, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_src;

  typedef struct {
    logic [3:0]   v;
    logic [19:0]  a;
    logic [127:0] d;
    logic [3:0]   ready;
    logic         flag;
    logic [4:0]   addr;
    logic [31:0]  data;
    logic [1:0]   src;
    logic         err;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) waited[i] = 0;
    m_flag = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0; m_src = '0;
  endtask

  // Starved requesters (waited a full LIMIT cycles) go first, lowest index first;
  // otherwise plain lowest-index-valid priority.
  function automatic int pick(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i] && waited[i] >= LIMIT) return i;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [19:0] pack_a(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [127:0] pack_d(input logic [31:0] d0, input logic [31:0] d1,
                                          input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".flag"}, 32'(bus.wb_flag_o), 32'(m_flag));
    check({tag, ".err"},  32'(bus.wb_err_o),  32'(m_err));
    check({tag, ".addr"}, 32'(bus.wb_addr_o), 32'(m_addr));
    check({tag, ".data"}, bus.wb_data_o,      m_data);
    check({tag, ".src"},  32'(bus.wb_src_o),  32'(m_src));
  endtask

  // One clock cycle: drive at negedge, check grant, advance model, check write port.
  task automatic step(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d,
                      output logic [3:0] rdy);
    int         g;
    logic [4:0] ad;
    bus.req_valid_i = v;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    #1;
    rdy = bus.req_ready_o;
    g   = pick(v);
    check("ready", 32'(rdy), (g < 0) ? 32'd0 : (32'd1 << g));
    for (int i = 0; i < 4; i++) begin
      if (!v[i] || i == g) waited[i] = 0;
      else if (waited[i] < LIMIT) waited[i]++;
    end
    if (g >= 0) begin
      ad     = a[5*g +: 5];
      m_addr = ad;
      m_data = d[32*g +: 32];
      m_src  = 2'(g);
      m_flag = (ad != 5'd0) && (ad < 5'd16);
      m_err  = (ad >= 5'd16);
    end else begin
      m_flag = 1'b0;
      m_err  = 1'b0;
    end
    @(negedge clk);
    check_outputs("wb");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]   rdy;
    logic [3:0]   v;
    logic [19:0]  a;
    logic [127:0] d;
    logic         pend [4];
    logic [4:0]   pa   [4];
    logic [31:0]  pd   [4];

    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst.flag", 32'(bus.wb_flag_o), 32'd0);
    check("rst.addr", 32'(bus.wb_addr_o), 32'd0);
    check("rst.data", bus.wb_data_o,      32'd0);
    check("rst.src",  32'(bus.wb_src_o),  32'd0);
    check("rst.err",  32'(bus.wb_err_o),  32'd0);
    rst_n = 1'b1;

    // Directed vectors: single write, fixed priority, filtering, idle hold
    tbl[0]  = '{4'b1000, pack_a(0,0,0,5), pack_d(0,0,0,32'hDEADBEEF), 4'b1000, 1, 5,  32'hDEADBEEF, 3, 0};
    tbl[1]  = '{4'b0000, '0,              '0,                          4'b0000, 0, 5,  32'hDEADBEEF, 3, 0};
    tbl[2]  = '{4'b1011, pack_a(1,2,0,3), pack_d(32'h11,32'h22,0,32'h33), 4'b0001, 1, 1, 32'h11, 0, 0};
    tbl[3]  = '{4'b1010, pack_a(1,2,0,3), pack_d(32'h11,32'h22,0,32'h33), 4'b0010, 1, 2, 32'h22, 1, 0};
    tbl[4]  = '{4'b1000, pack_a(1,2,0,3), pack_d(32'h11,32'h22,0,32'h33), 4'b1000, 1, 3, 32'h33, 3, 0};
    tbl[5]  = '{4'b0100, pack_a(0,0,0,0),  pack_d(0,0,32'h44,0),       4'b0100, 0, 0,  32'h44, 2, 0};
    tbl[6]  = '{4'b0100, pack_a(0,0,17,0), pack_d(0,0,32'h55,0),       4'b0100, 0, 17, 32'h55, 2, 1};
    tbl[7]  = '{4'b0100, pack_a(0,0,9,0),  pack_d(0,0,32'h12345678,0), 4'b0100, 1, 9, 32'h12345678, 2, 0};
    tbl[8]  = '{4'b0000, '0, '0, 4'b0000, 0, 9, 32'h12345678, 2, 0};
    tbl[9]  = '{4'b0000, '0, '0, 4'b0000, 0, 9, 32'h12345678, 2, 0};
    tbl[10] = '{4'b0000, '0, '0, 4'b0000, 0, 9, 32'h12345678, 2, 0};
    for (int k = 0; k < 11; k++) begin
      step(tbl[k].v, tbl[k].a, tbl[k].d, rdy);
      check($sformatf("vec%0d.ready", k), 32'(rdy), 32'(tbl[k].ready));
      check($sformatf("vec%0d.flag", k),  32'(bus.wb_flag_o), 32'(tbl[k].flag));
      check($sformatf("vec%0d.addr", k),  32'(bus.wb_addr_o), 32'(tbl[k].addr));
      check($sformatf("vec%0d.data", k),  bus.wb_data_o,      tbl[k].data);
      check($sformatf("vec%0d.src", k),   32'(bus.wb_src_o),  32'(tbl[k].src));
      check($sformatf("vec%0d.err", k),   32'(bus.wb_err_o),  32'(tbl[k].err));
    end

    // Starvation: LSU streams, ALU waits 4 cycles and wins the 5th
    for (int k = 0; k < 5; k++) begin
      step(4'b1010, pack_a(0, k + 1, 0, 7), pack_d(0, $urandom, 0, 32'hA1A1), rdy);
      check($sformatf("starve%0d", k), 32'(rdy), (k < 4) ? 32'h2 : 32'h8);
    end
    step(4'b0000, '0, '0, rdy);

    // Two saturate together behind a CSR stream: MDU first, ALU right after
    for (int k = 0; k < 6; k++) begin
      step(4'b1101, pack_a(k + 1, 0, 12, 13), pack_d($urandom, 0, 32'hC2, 32'hC3), rdy);
      check($sformatf("dual_urgent%0d", k), 32'(rdy),
            (k < 4) ? 32'h1 : ((k == 4) ? 32'h4 : 32'h8));
    end
    step(4'b0000, '0, '0, rdy);

    // Mid-operation reset with ALU part-way to saturation
    for (int k = 0; k < 3; k++) step(4'b1010, pack_a(0, 6 + k, 0, 10), pack_d(0, 32'hB0 + k, 0, 32'hAA), rdy);
    check("pre_rst.flag", 32'(bus.wb_flag_o), 32'd1);
    bus.req_addr_i = pack_a(0, 8, 0, 10);
    bus.req_data_i = pack_d(0, 32'hBEEF0008, 0, 32'hAA);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs("async_rst");
    @(negedge clk);
    check_outputs("held_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(4'b1010, pack_a(0, 8 + k, 0, 10), pack_d(0, 32'hBEEF0008 + k, 0, 32'hAA), rdy);
      check($sformatf("post_rst%0d", k), 32'(rdy), (k < 4) ? 32'h2 : 32'h8);
    end
    step(4'b0000, '0, '0, rdy);
    check("post_rst.idle_flag", 32'(bus.wb_flag_o), 32'd0);

    // Random traffic: requesters hold payloads until granted, rare early drops
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i]   = 5'($urandom_range(0, 31));
          pd[i]   = $urandom;
        end
        v[i] = pend[i];
        if (pend[i] && $urandom_range(0, 31) == 0) begin
          v[i]    = 1'b0;
          pend[i] = 1'b0;
        end
      end
      a = {pa[3], pa[2], pa[1], pa[0]};
      d = {pd[3], pd[2], pd[1], pd[0]};
      step(v, a, d, rdy);
      for (int i = 0; i < 4; i++) if (rdy[i]) pend[i] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_23060072_wb_arbiter.md
Name: ysyx_23060072_wb_arbiter

Overview:
- Shares the single register-file write port between four result producers: 0 = CSR, 1 = LSU, 2 = MDU, 3 = ALU.
- Grants one requester per cycle using fixed priority with starvation promotion.
- Registers the winner onto the writeback bus (flag/addr/data) that feeds the register file and the forwarding logic.
- Filters x0 writes and RV32E-illegal destination addresses.

Parameters:
- STARVE_LIMIT, 4: consecutive stalled cycles after which a waiting requester becomes urgent; legal range 1..(2^CNT_W - 1).
- CNT_W, 3: width of each per-requester starvation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  4  bit i = requester i has a result.
- req_ready_o  out  4  bit i = requester i is granted this cycle (combinational, one-hot or zero).
- req_addr_i  in  20  requester i destination in bits [5i+4:5i].
- req_data_i  in  128  requester i result in bits [32i+31:32i].
- wb_flag_o  out  1  register-file write enable (registered).
- wb_addr_o  out  5  write address (registered).
- wb_data_o  out  32  write data (registered).
- wb_src_o  out  2  index of the requester that produced the current wb_* (registered).
- wb_err_o  out  1  one-cycle pulse: an accepted write targeted x16..x31.

Behaviour:
- Handshake:
  - Transfer on req_valid_i[i] & req_ready_o[i].
  - A requester holds valid/addr/data stable until accepted.
  - A requester never drops valid before acceptance; if it does, its counter clears and no write occurs.
  - req_ready_o never asserts for a non-valid requester.
- Arbitration (combinational, every cycle):
  - urgent[i] = req_valid_i[i] & (cnt[i] == STARVE_LIMIT).
  - If any urgent bit is set, grant the lowest-index urgent requester.
  - Otherwise grant the lowest-index valid requester.
  - At most one grant per cycle. No valid requests means req_ready_o = 0.
- Starvation counters, per requester:
  - Clear to 0 when granted or when req_valid_i[i] = 0.
  - Increment when valid and not granted.
  - Saturate at STARVE_LIMIT.
- Output register (1-cycle latency from acceptance):
  - On acceptance, wb_addr_o <= addr and wb_data_o <= data; wb_src_o <= i.
  - wb_flag_o <= 1 only if addr != 0 and addr[4] == 0.
  - wb_err_o <= 1 if addr[4] == 1; wb_flag_o = 0 in that case.
  - addr == 0: accepted, wb_flag_o = 0, wb_err_o = 0.
  - Cycle with no acceptance: wb_flag_o <= 0 and wb_err_o <= 0; wb_addr_o, wb_data_o and wb_src_o hold their previous values.
  - Every accepted request produces exactly one output cycle; back-to-back acceptances give back-to-back writes with no bubble.
- Reset (asynchronous, mid-operation included):
  - wb_flag_o = 0, wb_addr_o = 0, wb_data_o = 0, wb_src_o = 0, wb_err_o = 0.
  - All counters = 0.
  - A request pending at reset is dropped. After rst_n rises it is re-arbitrated normally if still valid; no stale write is emitted.
- Simultaneous events:
  - Two requesters urgent in the same cycle: the lower index wins. The loser stays saturated and wins the next cycle unless a lower-index urgent requester appears.
  - Because of this rule, the worst-case wait for requester i is bounded by STARVE_LIMIT + i cycles.

Test Plan:
- Single request: after reset, ALU valid with addr 5, data 0xDEADBEEF for one cycle → req_ready_o = 4'b1000 that cycle. Next cycle wb_flag_o = 1, wb_addr_o = 5, wb_data_o = 0xDEADBEEF, wb_src_o = 3. The cycle after, wb_flag_o = 0.
- Fixed priority: CSR (addr 1), LSU (addr 2) and ALU (addr 3) valid together and held → grants in order CSR, LSU, ALU on three consecutive cycles. Outputs show addr 1, 2, 3 with wb_flag_o = 1 each cycle.
- Starvation: STARVE_LIMIT = 4; LSU asserts valid continuously with changing payloads, ALU holds valid → ALU stalls 4 cycles with its counter reaching 4, and is granted in the 5th cycle despite LSU being valid.
- Filtering:
  - MDU write to addr 0 → accepted; next cycle wb_flag_o = 0, wb_err_o = 0.
  - MDU write to addr 17 → accepted; next cycle wb_flag_o = 0, wb_err_o = 1 for exactly one cycle.
- Mid-operation reset: assert rst_n low while LSU is valid and wb_flag_o = 1 → all outputs and counters go to 0 immediately, without waiting for a clock edge. After release, LSU is granted on the first edge and its write appears once.
- Idle hold: after a write of 0x12345678 to addr 9, drive no requests for 3 cycles → wb_flag_o = 0 while wb_addr_o stays 9 and wb_data_o stays 0x12345678.
